mp3_ahb_fetch_master: RTL and testbench



---
 rtl/mp3_ahb_pkg.sv | 23 ++
 rtl/mp3_fetch_fifo.sv | 47 ++++
 rtl/mp3_ahb_fetch_master.sv | 153 +++++++++++++++
 tb/tb_mp3_ahb_fetch_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_ahb_pkg.sv
// Shared AHB-Lite encodings and fetch-master state type for the MP3 bitstream fetch path.
package mp3_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_INCR     = 3'b001;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LAST,
    ST_ERR
  } fetch_st_t;

  function automatic logic [31:0] byte_rev(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mp3_fetch_fifo.sv
// Synchronous word FIFO, DEPTH entries; pop data valid same cycle as pop_vld (no read latency).
// Push is dropped only when full with no simultaneous pop; the producer's credit check prevents that.
module mp3_fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 32,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic          pop_vld,
  output logic [W-1:0]  pop_dat,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] cnt;
  logic          wr_en, rd_en;

  assign pop_vld = (cnt != '0);
  assign rd_en   = pop_vld && pop_rdy;
  assign wr_en   = push_vld && ((cnt != LW'(DEPTH)) || rd_en);
  assign pop_dat = mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + LW'(wr_en) - LW'(rd_en);
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/mp3_ahb_fetch_master.sv
// AHB-Lite read master streaming word_cnt words from src_addr to m_*; first m_valid 3 cycles after start,
// issue stalls when FIFO credit runs out. Define MP3_FETCH_BYTESWAP_EN to byte-reverse each word.
module mp3_ahb_fetch_master #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 32,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [15:0]   word_cnt,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  output logic [3:0]    HPROT,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [31:0]   HRDATA,
  output logic          m_valid,
  output logic [31:0]   m_data,
  input  logic          m_ready,
  output logic [LW-1:0] fifo_level
);
  import mp3_ahb_pkg::*;

  fetch_st_t     state_q, state_n;
  logic [1:0]    htrans_q, htrans_n;
  logic [AW-1:0] haddr_q, haddr_n;
  logic [15:0]   rem_q, rem_n;
  logic          pend_q, pend_n;
  logic          done_q, done_n;
  logic          acc, err_first, push, pop, credit;
  logic [31:0]   wr_dat;

  assign acc       = HREADY && (htrans_q != HTRANS_IDLE);
  assign err_first = pend_q && HRESP && !HREADY;
  assign push      = pend_q && HREADY && !HRESP;
  assign pop       = m_valid && m_ready;
  assign pend_n    = acc || (pend_q && !HREADY && !err_first);
  // One more beat may be issued only if it is guaranteed a FIFO slot next cycle.
  assign credit    = (int'(fifo_level) + int'(push) - int'(pop) + int'(pend_n) + 1) <= DEPTH;

`ifdef MP3_FETCH_BYTESWAP_EN
  assign wr_dat = byte_rev(HRDATA);
`else
  assign wr_dat = HRDATA;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    htrans_n = htrans_q;
    haddr_n  = haddr_q;
    rem_n    = rem_q;
    done_n   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_cnt == '0) begin
            done_n = 1'b1;
          end else begin
            state_n  = ST_ADDR;
            haddr_n  = src_addr & ~AW'(3);
            rem_n    = word_cnt;
            htrans_n = credit ? HTRANS_NONSEQ : HTRANS_IDLE;
          end
        end
      end
      ST_ADDR: begin
        if (err_first) begin
          state_n  = ST_ERR;
          htrans_n = HTRANS_IDLE;
        end else if (HREADY) begin
          if (acc) begin
            haddr_n = haddr_q + AW'(4);
            rem_n   = rem_q - 16'd1;
          end
          if (rem_n == '0) begin
            state_n  = ST_LAST;
            htrans_n = HTRANS_IDLE;
          end else if (credit) begin
            // Restart a burst after an idle cycle or when crossing a 1 KB boundary.
            htrans_n = (!acc || haddr_n[9:0] == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
          end else begin
            htrans_n = HTRANS_IDLE;
          end
        end
      end
      ST_LAST: begin
        if (err_first) begin
          state_n = ST_ERR;
        end else if (push) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      ST_ERR: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_ADDR) || (state_q == ST_LAST);
    err  = (state_q == ST_ERR);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      rem_q    <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      htrans_q <= htrans_n;
      haddr_q  <= haddr_n;
      rem_q    <= rem_n;
      pend_q   <= pend_n;
      done_q   <= done_n;
    end
  end

  assign done   = done_q;
  assign HADDR  = haddr_q;
  // Only the first ERROR cycle bypasses the register to cancel the queued address phase.
  assign HTRANS = err_first ? HTRANS_IDLE : htrans_q;
  assign HWRITE = 1'b0;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_INCR;
  assign HPROT  = HPROT_DATA_PRIV;

  mp3_fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .push_vld (push),
    .push_dat (wr_dat),
    .pop_rdy  (m_ready),
    .pop_vld  (m_valid),
    .pop_dat  (m_data),
    .level    (fifo_level)
  );

endmodule

// File: tb/tb_mp3_ahb_fetch_master.sv
// Directed bench for mp3_ahb_fetch_master with a zero-wait AHB slave model and one injectable ERROR address.
module tb_mp3_ahb_fetch_master;
  import mp3_ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start;
  logic [31:0] src_addr;
  logic [15:0] word_cnt;
  logic        busy, done, err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADY, HRESP;
  logic [31:0] HRDATA;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic [2:0]  fifo_level;

  always #5 HCLK = ~HCLK;

  mp3_ahb_fetch_master #(.DEPTH(4), .AW(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .err(err), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .fifo_level(fifo_level)
  );

  // Slave: zero wait states, data = address ^ 0xDEAD0000, two-cycle ERROR on err_addr.
  logic        dph_vld, err_cyc;
  logic [31:0] dph_addr;
  logic [31:0] err_addr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_vld  <= 1'b0;
      dph_addr <= '0;
      err_cyc  <= 1'b0;
    end else begin
      if (HREADY) begin
        dph_vld  <= HTRANS[1];
        dph_addr <= HADDR;
      end
      err_cyc <= HRESP && !err_cyc;
    end
  end

  assign HRESP  = dph_vld && (dph_addr == err_addr);
  assign HREADY = !(HRESP && !err_cyc);
  assign HRDATA = dph_vld ? (dph_addr ^ 32'hDEAD_0000) : 32'h0;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [31:0] w;
    w = a ^ 32'hDEAD_0000;
`ifdef MP3_FETCH_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  logic [31:0] bus_addr_q[$];
  logic [1:0]  bus_trans_q[$];
  logic [1:0]  err_trans_q[$];
  logic [31:0] out_q[$];
  int          out_cyc_q[$];
  int          done_cyc_q[$];
  int          err_cnt = 0;

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (HREADY && HTRANS != HTRANS_IDLE) begin
        bus_addr_q.push_back(HADDR);
        bus_trans_q.push_back(HTRANS);
      end
      if (HRESP && !HREADY) err_trans_q.push_back(HTRANS);
      if (m_valid && m_ready) begin
        out_q.push_back(m_data);
        out_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (err) err_cnt++;
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int start_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
    @(posedge HCLK);
    #1;
    start     = 1'b1;
    src_addr  = a;
    word_cnt  = n;
    start_cyc = cyc;
    @(posedge HCLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int db, input int eb, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cyc_q.size() == db && err_cnt == eb && n < budget) begin
      @(negedge HCLK);
      #1;
      n++;
    end
    chk(tag, (done_cyc_q.size() == db && err_cnt == eb), 1'b0);
  endtask

  task automatic chk_beats(input string tag, input int ab, input logic [31:0] base, input int n, input int resync);
    chk({tag, "_nbeats"}, bus_addr_q.size() - ab, n);
    for (int i = 0; i < n; i++) begin
      if (ab + i < bus_addr_q.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), bus_addr_q[ab+i], base + 32'(4 * i));
        chk($sformatf("%s_trans%0d", tag, i), bus_trans_q[ab+i],
            (i == 0 || i == resync) ? HTRANS_NONSEQ : HTRANS_SEQ);
      end
    end
  endtask

  task automatic chk_out(input string tag, input int ob, input logic [31:0] base, input int n);
    chk({tag, "_nout"}, out_q.size() - ob, n);
    for (int i = 0; i < n; i++) begin
      if (ob + i < out_q.size())
        chk($sformatf("%s_dat%0d", tag, i), out_q[ob+i], exp_word(base + 32'(4 * i)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int ab, ob, db, eb, tb_n;
    HRESETn  = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    word_cnt = '0;
    m_ready  = 1'b1;
    err_addr = 32'hFFFF_FFFF;
    idle(3);
    chk("rst_htrans", HTRANS, HTRANS_IDLE);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    HRESETn = 1'b1;
    idle(2);
    chk("ctl_hwrite", HWRITE, 1'b0);
    chk("ctl_hsize", HSIZE, 3'b010);
    chk("ctl_hburst", HBURST, 3'b001);
    chk("ctl_hprot", HPROT, 4'b0011);

    // 8-word burst, zero wait, consumer always ready; a second start while busy is ignored
    ab = bus_addr_q.size(); ob = out_q.size(); db = done_cyc_q.size(); eb = err_cnt;
    pulse_start(32'h0000_1000, 16'd8);
    tb_n = start_cyc;
    chk("t1_busy", busy, 1'b1);
    pulse_start(32'h0000_8000, 16'd3);
    start_cyc = tb_n;
    wait_end(db, eb, 40, "t1_timeout");
    idle(3);
    chk_beats("t1", ab, 32'h0000_1000, 8, 0);
    chk_out("t1", ob, 32'h0000_1000, 8);
    if (out_q.size() > ob) chk("t1_first_vld", out_q.size() > ob ? out_cyc_q[ob] - start_cyc : -1, 3);
    if (done_cyc_q.size() > db) chk("t1_done_lat", done_cyc_q[db] - start_cyc, 10);
    chk("t1_done_cnt", done_cyc_q.size() - db, 1);
    chk("t1_busy_end", busy, 1'b0);

    // 1 KB boundary crossing forces NONSEQ at 0x1400
    ab = bus_addr_q.size(); ob = out_q.size(); db = done_cyc_q.size(); eb = err_cnt;
    pulse_start(32'h0000_13F8, 16'd4);
    wait_end(db, eb, 30, "t2_timeout");
    idle(3);
    chk_beats("t2", ab, 32'h0000_13F8, 4, 2);
    chk_out("t2", ob, 32'h0000_13F8, 4);

    // Credit stall: consumer blocked, only DEPTH beats issued, then resume
    ab = bus_addr_q.size(); ob = out_q.size(); db = done_cyc_q.size(); eb = err_cnt;
    m_ready = 1'b0;
    pulse_start(32'h0000_2000, 16'd10);
    idle(12);
    chk("t3_stall_beats", bus_addr_q.size() - ab, 4);
    chk("t3_stall_htrans", HTRANS, HTRANS_IDLE);
    chk("t3_stall_level", fifo_level, 3'd4);
    chk("t3_stall_busy", busy, 1'b1);
    chk("t3_stall_mvalid", m_valid, 1'b1);
    m_ready = 1'b1;
    wait_end(db, eb, 60, "t3_timeout");
    idle(4);
    chk_beats("t3", ab, 32'h0000_2000, 10, 4);
    chk_out("t3", ob, 32'h0000_2000, 10);
    chk("t3_done_cnt", done_cyc_q.size() - db, 1);

    // ERROR on the third beat of six
    ab = bus_addr_q.size(); ob = out_q.size(); db = done_cyc_q.size(); eb = err_cnt;
    tb_n = err_trans_q.size();
    m_ready  = 1'b0;
    err_addr = 32'h0000_3008;
    pulse_start(32'h0000_3000, 16'd6);
    wait_end(db, eb, 20, "t4_timeout");
    chk("t4_err_cnt", err_cnt - eb, 1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_level", fifo_level, 3'd2);
    chk("t4_nerrcyc", err_trans_q.size() - tb_n, 1);
    if (err_trans_q.size() > tb_n) chk("t4_htrans_err", err_trans_q[tb_n], HTRANS_IDLE);
    idle(5);
    chk("t4_nbeats", bus_addr_q.size() - ab, 3);
    chk("t4_no_done", done_cyc_q.size() - db, 0);
    chk("t4_err_once", err_cnt - eb, 1);
    err_addr = 32'hFFFF_FFFF;
    m_ready  = 1'b1;
    idle(4);
    chk_out("t4", ob, 32'h0000_3000, 2);

    // Zero-length request
    ab = bus_addr_q.size(); db = done_cyc_q.size();
    pulse_start(32'h0000_4000, 16'd0);
    idle(3);
    chk("t5_done_cnt", done_cyc_q.size() - db, 1);
    if (done_cyc_q.size() > db) chk("t5_done_lat", done_cyc_q[db] - start_cyc, 1);
    chk("t5_nbeats", bus_addr_q.size() - ab, 0);
    chk("t5_busy", busy, 1'b0);

    // Reset mid-transfer, then a clean fetch
    m_ready = 1'b0;
    pulse_start(32'h0000_5000, 16'd8);
    idle(3);
    HRESETn = 1'b0;
    #1;
    chk("t6_htrans", HTRANS, HTRANS_IDLE);
    chk("t6_haddr", HADDR, 32'h0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_err", err, 1'b0);
    chk("t6_mvalid", m_valid, 1'b0);
    chk("t6_level", fifo_level, 3'd0);
    idle(2);
    HRESETn = 1'b1;
    m_ready = 1'b1;
    idle(1);
    ab = bus_addr_q.size(); ob = out_q.size(); db = done_cyc_q.size(); eb = err_cnt;
    pulse_start(32'h0000_6000, 16'd3);
    wait_end(db, eb, 30, "t6_timeout");
    idle(3);
    chk_beats("t6", ab, 32'h0000_6000, 3, 0);
    chk_out("t6", ob, 32'h0000_6000, 3);
    if (done_cyc_q.size() > db) chk("t6_done_lat", done_cyc_q[db] - start_cyc, 5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
